uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive-side counterpart of the UART transmit datapath. Frames 8N1 serial data, LSB first, idle-high, from the external rx pin into bytes.
- Single-module controller and datapath: input synchronizer, baud counter, bit counter, SIPO shift register, and a holding register with a valid/ready handshake to the downstream consumer.
- Default baud divisor matches TX: 868 clk cycles per bit (100 MHz, 115200 baud).

Parameters:
BAUD, 868, clk cycles per bit; must be >= 8
HALF_BAUD, BAUD/2 (434), cycles from start-bit falling edge to start-bit mid-sample

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_in  input  1  serial line from pin; asynchronous to clk; idle high
rx_ready  input  1  consumer accepts rx_data on any clk edge where rx_valid=1
rx_data  output  8  last good received byte; stable while rx_valid=1
rx_valid  output  1  holding register full
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: frame completed while holding register full and not being accepted

Behaviour:
- Reset (async, active-high):
  - rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_overrun=0.
  - Synchronizer flops=1, state=IDLE, counters=0, shift reg=8'hFF.
  - Reset mid-frame aborts the frame; no output pulses are generated.
- Synchronizer: 2-FF; all logic uses the synced bit rxs (2-cycle latency).
- Baud counter: clears on every state entry. A "tick" occurs when the count equals (limit-1); the counter then clears.
  - limit=HALF_BAUD in START; limit=BAUD in DATA, PARITY and STOP.
  - Width $clog2(BAUD+1).
- Bit counter: 0..7 in DATA, 3 bits.
- States:
  - IDLE: rxs==0 -> START.
  - START: on tick, rxs==0 -> DATA (bit counter=0). If rxs==1, glitch rejected -> IDLE, no pulses.
  - DATA: on tick, shift reg <= {rxs, sr[7:1]}. Bit counter 7 -> STOP (or PARITY if enabled); otherwise increment.
  - STOP: on tick:
    - rxs==1 -> commit, then IDLE.
    - rxs==0 -> rx_frame_err pulse, data discarded -> BREAK.
  - BREAK: wait for rxs==1 -> IDLE; a held-low line (break) yields exactly one error pulse.
- Commit at the stop-sample edge:
  - If rx_valid==0 or rx_ready==1: rx_data<=sr, rx_valid<=1.
  - Else: rx_overrun pulse; old rx_data and rx_valid are kept; new byte is dropped.
- Handshake:
  - rx_valid clears on the edge where rx_valid&rx_ready and no commit occurs.
  - Simultaneous accept and commit: new byte loads and rx_valid stays 1.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be received with no gap.
- Latency, falling edge of rx_in to rx_valid rising: 2 + HALF_BAUD + 9*BAUD cycles (8248 at defaults), ±1 for synchronizer phase.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - An even-parity bit follows the 8 data bits; PARITY state samples it on a BAUD tick, then -> STOP.
  - Adds output rx_parity_err: one-cycle pulse at commit time when (^sr ^ parity_bit)!=0. Byte is still committed.
  - Latency becomes 2 + HALF_BAUD + 10*BAUD.
- Undefined: no PARITY state, no rx_parity_err port; 8N1 only.

Decomposition:
- Shared package/include uart_pkg: default BAUD (868), the rx state encodings (IDLE, START, DATA, PARITY, STOP, BREAK), and the TX tx_out_sel / shift_tx_sel codes, so TX and RX share one source.
- One natural sub-module, uart_rx_sync: 2-FF synchronizer, reset value 1.
- The rest is flat in uart_rx.

Test Plan:
- Frame 8'hA5 (line: 0,1,0,1,0,0,1,0,1,1) at BAUD=868, rx_ready=1 -> rx_data=8'hA5, rx_valid high for 1 cycle, 8248±1 cycles after the falling edge; no error pulses.
- 200-cycle low glitch on idle line -> state returns to IDLE; no rx_valid, rx_frame_err or rx_overrun.
- Frame 8'h3C with stop bit driven 0, line then held low 5000 cycles, then high -> exactly one rx_frame_err pulse; rx_valid stays 0; next frame 8'h81 received correctly.
- Back-to-back frames 8'h01, 8'h02 with no idle gap, rx_ready=0 -> rx_data=8'h01, rx_valid=1, one rx_overrun pulse at the second stop sample; then rx_ready=1 for one cycle -> rx_valid=0.
- Reset asserted mid-frame (after bit 3 of 8'hFF) -> outputs at reset values immediately; after release, frame 8'h5A is received correctly.
- With UART_RX_PARITY_EN: frame 8'h07 sent with parity bit 0 (wrong; even parity requires 1) -> rx_data=8'h07, rx_valid=1, rx_parity_err pulse on the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, RX state encoding and TX mux select codes,
// kept in one place so the transmit and receive sides agree.
package uart_pkg;

  localparam int BAUD_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_OUT_IDLE  = 2'd0,
    TX_OUT_START = 2'd1,
    TX_OUT_DATA  = 2'd2,
    TX_OUT_STOP  = 2'd3
  } tx_out_sel_t;

  typedef enum logic [1:0] {
    SHIFT_TX_HOLD  = 2'd0,
    SHIFT_TX_LOAD  = 2'd1,
    SHIFT_TX_SHIFT = 2'd2
  } shift_tx_sel_t;

  function automatic logic even_parity_err(input logic [7:0] bits, input logic par);
    return (^bits) ^ par;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle (high) line level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, with a valid/ready holding register.
// Define UART_RX_PARITY_EN for an even-parity bit and the rx_parity_err output. BAUD must be >= 8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD      = BAUD_DEFAULT,
  parameter int HALF_BAUD = BAUD / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CW = $clog2(BAUD + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BAUD - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic          rxs;
  logic          tick;
  logic          accept;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rxs)
  );

  always_comb begin
    tick = 1'b0;
    case (state)
      START:             tick = (cnt == HALF_LAST);
      DATA, PARITY, STOP: tick = (cnt == BAUD_LAST);
      default:           tick = 1'b0;
    endcase
  end

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= 8'hFF;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      // A commit below overrides this clear, so accept+commit keeps rx_valid high.
      if (accept) rx_valid <= 1'b0;
      cnt <= tick ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick) begin
            sr <= {rxs, sr[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bit <= rxs;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rxs) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= sr;
                rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                rx_parity_err <= even_parity_err(sr, par_bit);
`endif
              end else begin
                rx_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at the default 868-cycle baud divisor.
module tb_uart_rx;

  localparam int BAUD = 868;
  localparam int HALF = BAUD / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam int LAT = 2 + HALF + NBITS * BAUD;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
  logic       corrupt_par = 1'b0;
`endif

  uart_rx #(.BAUD(BAUD), .HALF_BAUD(HALF)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed events, sampled on the falling edge.
  int         cyc = 0;
  int         rises = 0;
  int         hi_cycles = 0;
  int         ferrs = 0;
  int         ovrs = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;
`ifdef UART_RX_PARITY_EN
  int         perrs = 0;
  int         perr_cyc = -1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rises     <= rises + 1;
      rise_data <= rx_data;
      rise_cyc  <= cyc;
    end
    if (rx_valid)     hi_cycles <= hi_cycles + 1;
    if (rx_frame_err) ferrs <= ferrs + 1;
    if (rx_overrun)   ovrs <= ovrs + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) begin
      perrs    <= perrs + 1;
      perr_cyc <= cyc;
    end
`endif
    prev_valid <= rx_valid;
  end

  // Reference model: what the holding register and pulse counts should be after each frame.
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  int         exp_rises = 0;
  int         exp_ferrs = 0;
  int         exp_ovrs = 0;
`ifdef UART_RX_PARITY_EN
  int         exp_perrs = 0;
`endif

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ corrupt_par);
`endif
    send_bit(stop);
    if (!stop) begin
      exp_ferrs++;
    end else if (!exp_valid || rx_ready) begin
      if (!exp_valid) exp_rises++;
      exp_data  = d;
      exp_valid = !rx_ready;
`ifdef UART_RX_PARITY_EN
      if (corrupt_par) exp_perrs++;
`endif
    end else begin
      exp_ovrs++;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         t0;
  logic [7:0] rnd;

  initial begin
    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_data", rx_data, 8'h00);
    check_eq("reset_valid", rx_valid, 1'b0);
    check_eq("reset_frame_err", rx_frame_err, 1'b0);
    check_eq("reset_overrun", rx_overrun, 1'b0);
    reset = 1'b0;
    idle(20 + $urandom_range(0, 7));

    // Single good frame, consumer always ready
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(HALF);
    check_eq("a5_latency_in_window",
             ((rise_cyc - t0) >= LAT - 1) && ((rise_cyc - t0) <= LAT + 1), 1'b1);
    check_eq("a5_data", rise_data, exp_data);
    check_eq("a5_rises", rises, exp_rises);
    check_eq("a5_valid_one_cycle", hi_cycles, 1);
    check_eq("a5_frame_err", ferrs, exp_ferrs);
    check_eq("a5_overrun", ovrs, exp_ovrs);

    // Short low glitch on an idle line
    rx_in = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    idle(BAUD + 200);
    check_eq("glitch_rises", rises, exp_rises);
    check_eq("glitch_frame_err", ferrs, exp_ferrs);
    check_eq("glitch_overrun", ovrs, exp_ovrs);
    check_eq("glitch_valid", rx_valid, 1'b0);

    // Bad stop bit followed by a long break, then a good frame
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    check_eq("break_frame_err_once", ferrs, exp_ferrs);
    check_eq("break_no_valid", rises, exp_rises);
    idle(BAUD + $urandom_range(0, 50));
    send_frame(8'h81, 1'b1);
    idle(HALF);
    check_eq("after_break_data", rise_data, exp_data);
    check_eq("after_break_rises", rises, exp_rises);
    check_eq("after_break_frame_err", ferrs, exp_ferrs);

    // Back-to-back frames with the consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle(10);
    check_eq("b2b_valid", rx_valid, exp_valid);
    check_eq("b2b_data", rx_data, exp_data);
    check_eq("b2b_overrun", ovrs, exp_ovrs);
    check_eq("b2b_rises", rises, exp_rises);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready  = 1'b0;
    exp_valid = 1'b0;
    check_eq("b2b_accept_clears", rx_valid, exp_valid);
    check_eq("b2b_data_after_accept", rx_data, exp_data);

    // Random byte held, then reset in the middle of the next frame
    rnd = 8'($urandom_range(0, 255));
    send_frame(rnd, 1'b1);
    idle(10);
    check_eq("rand_valid", rx_valid, exp_valid);
    check_eq("rand_data", rx_data, exp_data);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #3 reset = 1'b1;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    #1;
    check_eq("midreset_data", rx_data, exp_data);
    check_eq("midreset_valid", rx_valid, exp_valid);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_ready = 1'b1;
    idle(BAUD);
    check_eq("midreset_no_frame_err", ferrs, exp_ferrs);
    check_eq("midreset_no_overrun", ovrs, exp_ovrs);
    send_frame(8'h5A, 1'b1);
    idle(HALF);
    check_eq("post_reset_data", rise_data, exp_data);
    check_eq("post_reset_rises", rises, exp_rises);
    check_eq("post_reset_overrun", ovrs, exp_ovrs);

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte committed with a coincident parity error pulse
    check_eq("parity_none_yet", perrs, exp_perrs);
    corrupt_par = 1'b1;
    send_frame(8'h07, 1'b1);
    corrupt_par = 1'b0;
    idle(HALF);
    check_eq("parity_data", rise_data, exp_data);
    check_eq("parity_err_count", perrs, exp_perrs);
    check_eq("parity_err_same_cycle", perr_cyc, rise_cyc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
